// File: rtl/ysyx_25060170_pkg.sv
// Shared write-back definitions for the NPC core.
// Register address width and the buffered entry layout.
package ysyx_25060170_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_25060170_WBFIFO.sv
// EXU result buffer in front of the GPR write port.
// Invalid slots report rd=0 so they never match a query.
module ysyx_25060170_WBFIFO
    import ysyx_25060170_pkg::*;
#(
    parameter int XLEN  = ysyx_25060170_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [REG_ADDR_W-1:0]       push_rd,
    input  logic [XLEN-1:0]             push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [REG_ADDR_W-1:0]       head_rd,
    output logic [XLEN-1:0]             head_data,
    output logic [DEPTH*REG_ADDR_W-1:0] valid_rds
);

    localparam int PW = $clog2(DEPTH);

    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]       data_mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW:0]           count;
    logic [PW-1:0]         off;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_rd   = rd_mem[rptr];
    assign head_data = data_mem[rptr];

    // Entry storage; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr]   <= push_rd;
            data_mem[wptr] <= push_data;
        end
    end

    // Pointers and occupancy; reset drops every buffered entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Expose rd of every occupied slot for the pending-write scoreboard.
    always_comb begin
        valid_rds = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rptr;
            if ({1'b0, off} < count)
                valid_rds[i*REG_ADDR_W +: REG_ADDR_W] = rd_mem[i];
        end
    end

endmodule

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: arbitrates LSU and buffered EXU results onto
// the single GPR write port and answers pending-write queries.
module ysyx_25060170_wbu
    import ysyx_25060170_pkg::*;
#(
    parameter int XLEN  = ysyx_25060170_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [REG_ADDR_W-1:0] exu_rd,
    input  logic [XLEN-1:0]       exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  GPR_we,
    output logic [REG_ADDR_W-1:0] GPR_writer,
    output logic [XLEN-1:0]       GPR_wd,
    output logic                  wb_valid,
    output logic [31:0]           retire_cnt,
    input  logic [REG_ADDR_W-1:0] chk_rs,
    output logic                  chk_busy
);

    logic                        full;
    logic                        empty;
    logic                        push;
    logic                        pop;
    logic                        load;
    logic                        lsu_fire;
    logic                        exu_fire;
    logic [REG_ADDR_W-1:0]       head_rd;
    logic [XLEN-1:0]             head_data;
    logic [REG_ADDR_W-1:0]       sel_rd;
    logic [XLEN-1:0]             sel_data;
    logic [DEPTH*REG_ADDR_W-1:0] valid_rds;

    // A full buffer blocks LSU too, guaranteeing the head drains.
    assign lsu_ready = !full;
    assign exu_ready = !full;
    assign lsu_fire  = lsu_valid && !full;
    assign exu_fire  = exu_valid && !full;

    ysyx_25060170_WBFIFO #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (exu_rd),
        .push_data (exu_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_rd   (head_rd),
        .head_data (head_data),
        .valid_rds (valid_rds)
    );

    // Source priority: LSU, then buffer head, then EXU bypass.
    always_comb begin
        load     = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        sel_rd   = head_rd;
        sel_data = head_data;
        if (lsu_fire) begin
            load     = 1'b1;
            push     = exu_fire;
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end else if (!empty) begin
            load = 1'b1;
            pop  = 1'b1;
            push = exu_fire;
        end else if (exu_fire) begin
            load     = 1'b1;
            sel_rd   = exu_rd;
            sel_data = exu_data;
        end
    end

    // Output register and retire counter; x0 writes retire without we.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            GPR_we     <= 1'b0;
            GPR_writer <= '0;
            GPR_wd     <= '0;
            wb_valid   <= 1'b0;
            retire_cnt <= '0;
        end else begin
            wb_valid <= load;
            GPR_we   <= load && (sel_rd != '0);
            if (load) begin
                GPR_writer <= sel_rd;
                GPR_wd     <= sel_data;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    // Pending write: any buffered entry or the write in the register.
    always_comb begin
        chk_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (valid_rds[i*REG_ADDR_W +: REG_ADDR_W] == chk_rs)
                chk_busy = 1'b1;
        if (GPR_we && (GPR_writer == chk_rs))
            chk_busy = 1'b1;
        if (chk_rs == '0)
            chk_busy = 1'b0;
    end

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Self-checking bench for the write-back unit.
// Scoreboard of expected retires plus a small arbitration model.
module tb_ysyx_25060170_wbu;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        GPR_we;
    logic [4:0]  GPR_writer;
    logic [31:0] GPR_wd;
    logic        wb_valid;
    logic [31:0] retire_cnt;
    logic [4:0]  chk_rs;
    logic        chk_busy;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    logic [4:0]  mrd[$];
    logic [31:0] mdata[$];
    logic [4:0]  out_rd_m;
    logic        out_we_m;
    logic [31:0] rc_m;
    int          nvec;
    int          nfail;

    ysyx_25060170_wbu #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_rd     (exu_rd),
        .exu_data   (exu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .GPR_we     (GPR_we),
        .GPR_writer (GPR_writer),
        .GPR_wd     (GPR_wd),
        .wb_valid   (wb_valid),
        .retire_cnt (retire_cnt),
        .chk_rs     (chk_rs),
        .chk_busy   (chk_busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every retire must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (rst === 1'b1 && wb_valid === 1'b1) begin
            nvec++;
            if (expq.size() == 0) begin
                nfail++;
                $display("FAIL retire_unexpected got rd=%0d wd=%h",
                         GPR_writer, GPR_wd);
            end else begin
                mon_e = expq.pop_front();
                if (GPR_writer !== mon_e.rd || GPR_wd !== mon_e.data ||
                    GPR_we !== mon_e.we) begin
                    nfail++;
                    $display("FAIL retire got rd=%0d wd=%h we=%b exp rd=%0d wd=%h we=%b",
                             GPR_writer, GPR_wd, GPR_we,
                             mon_e.rd, mon_e.data, mon_e.we);
                end
            end
        end
    end

    function automatic void model_clear();
        expq.delete();
        mrd.delete();
        mdata.delete();
        out_rd_m = '0;
        out_we_m = 1'b0;
        rc_m     = '0;
    endfunction

    function automatic void model_load(input logic [4:0] rd,
                                       input logic [31:0] d);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        e.we   = (rd != 0);
        expq.push_back(e);
        out_rd_m = rd;
        out_we_m = (rd != 0);
        rc_m     = rc_m + 32'd1;
    endfunction

    // One clock of stimulus; checks readiness and the scoreboard query.
    task automatic cycle(input logic lv, input logic [4:0] lrd,
                         input logic [31:0] ld, input logic xv,
                         input logic [4:0] xrd, input logic [31:0] xd,
                         input logic [4:0] rs,
                         output logic lf, output logic xf);
        logic rdy;
        logic bsy;
        logic byp;
        @(negedge clk);
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
        exu_valid = xv;
        exu_rd    = xrd;
        exu_data  = xd;
        chk_rs    = rs;
        #1;
        rdy = (mrd.size() != DEPTH);
        bsy = 1'b0;
        foreach (mrd[i]) if (mrd[i] == rs) bsy = 1'b1;
        if (out_we_m && out_rd_m == rs) bsy = 1'b1;
        if (rs == 0) bsy = 1'b0;
        nvec++;
        if (exu_ready !== rdy || lsu_ready !== rdy) begin
            nfail++;
            $display("FAIL ready got exu=%b lsu=%b exp %b",
                     exu_ready, lsu_ready, rdy);
        end
        nvec++;
        if (chk_busy !== bsy) begin
            nfail++;
            $display("FAIL chk_busy rs=%0d got %b exp %b", rs, chk_busy, bsy);
        end
        lf  = lv & rdy;
        xf  = xv & rdy;
        byp = 1'b0;
        if (lf) begin
            model_load(lrd, ld);
        end else if (mrd.size() > 0) begin
            model_load(mrd.pop_front(), mdata.pop_front());
        end else if (xf) begin
            model_load(xrd, xd);
            byp = 1'b1;
        end else begin
            out_we_m = 1'b0;
        end
        if (xf && !byp) begin
            mrd.push_back(xrd);
            mdata.push_back(xd);
        end
    endtask

    task automatic idle(input logic [4:0] rs);
        logic lf, xf;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rs, lf, xf);
    endtask

    task automatic drain_check(input string name);
        for (int i = 0; i < 10 && (expq.size() != 0 || mrd.size() != 0); i++)
            idle(5'd0);
        idle(5'd0);
        nvec++;
        if (expq.size() != 0) begin
            nfail++;
            $display("FAIL %s_lost got %0d pending exp 0", name, expq.size());
        end
        nvec++;
        if (retire_cnt !== rc_m) begin
            nfail++;
            $display("FAIL %s_count got %0d exp %0d", name, retire_cnt, rc_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        exu_valid = 0; exu_rd = 0; exu_data = 0;
        chk_rs = 5'd0;
        model_clear();
        #3;
        nvec++;
        if (GPR_we !== 1'b0 || GPR_writer !== 5'd0 || GPR_wd !== 32'd0 ||
            wb_valid !== 1'b0 || retire_cnt !== 32'd0) begin
            nfail++;
            $display("FAIL reset_outputs got we=%b wr=%0d wd=%h v=%b cnt=%0d exp zeros",
                     GPR_we, GPR_writer, GPR_wd, wb_valid, retire_cnt);
        end
        nvec++;
        if (exu_ready !== 1'b1 || lsu_ready !== 1'b1 || chk_busy !== 1'b0) begin
            nfail++;
            $display("FAIL reset_ready got exu=%b lsu=%b busy=%b exp 1 1 0",
                     exu_ready, lsu_ready, chk_busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_bypass();
        logic lf, xf;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5, lf, xf);
        idle(5'd5);
        nvec++;
        if (GPR_we !== 1'b1 || GPR_writer !== 5'd5 || GPR_wd !== 32'h1234 ||
            retire_cnt !== 32'd1) begin
            nfail++;
            $display("FAIL bypass got we=%b wr=%0d wd=%h cnt=%0d exp 1 5 1234 1",
                     GPR_we, GPR_writer, GPR_wd, retire_cnt);
        end
        drain_check("bypass");
    endtask

    task automatic test_simultaneous();
        logic lf, xf;
        cycle(1'b1, 5'd4, 32'hB, 1'b1, 5'd3, 32'hA, 5'd3, lf, xf);
        idle(5'd3);
        nvec++;
        if (GPR_writer !== 5'd4 || GPR_wd !== 32'hB || chk_busy !== 1'b1) begin
            nfail++;
            $display("FAIL simul_first got wr=%0d wd=%h busy=%b exp 4 b 1",
                     GPR_writer, GPR_wd, chk_busy);
        end
        idle(5'd3);
        nvec++;
        if (GPR_writer !== 5'd3 || GPR_wd !== 32'hA || GPR_we !== 1'b1) begin
            nfail++;
            $display("FAIL simul_second got wr=%0d wd=%h we=%b exp 3 a 1",
                     GPR_writer, GPR_wd, GPR_we);
        end
        drain_check("simul");
    endtask

    task automatic test_full();
        logic lf, xf;
        int li = 0;
        int xi = 0;
        for (int c = 0; c < 20 && (li < 6 || xi < 2); c++) begin
            cycle(li < 6, 5'(10 + li), 32'h100 + 32'(li),
                  xi < 2, 5'(20 + xi), 32'h200 + 32'(xi),
                  5'(20 + (c % 2)), lf, xf);
            if (lf) li++;
            if (xf) xi++;
        end
        drain_check("full");
    endtask

    task automatic test_rd0();
        logic lf, xf;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 5'd0, lf, xf);
        idle(5'd0);
        nvec++;
        if (wb_valid !== 1'b1 || GPR_we !== 1'b0 || chk_busy !== 1'b0 ||
            retire_cnt !== rc_m) begin
            nfail++;
            $display("FAIL rd0 got v=%b we=%b busy=%b cnt=%0d exp 1 0 0 %0d",
                     wb_valid, GPR_we, chk_busy, retire_cnt, rc_m);
        end
        drain_check("rd0");
    endtask

    task automatic test_wrap();
        logic lf, xf;
        @(negedge clk);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        rc_m = 32'hFFFF_FFFF;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 5'd0, lf, xf);
        idle(5'd0);
        nvec++;
        if (retire_cnt !== 32'd0) begin
            nfail++;
            $display("FAIL wrap got %h exp 0", retire_cnt);
        end
        drain_check("wrap");
    endtask

    task automatic test_midreset();
        logic lf, xf;
        cycle(1'b1, 5'd11, 32'h11, 1'b1, 5'd21, 32'h21, 5'd0, lf, xf);
        cycle(1'b1, 5'd12, 32'h12, 1'b1, 5'd22, 32'h22, 5'd0, lf, xf);
        @(negedge clk);
        lsu_valid = 1'b0;
        exu_valid = 1'b0;
        chk_rs    = 5'd21;
        #2;
        rst = 1'b0;
        #1;
        nvec++;
        if (GPR_we !== 1'b0 || GPR_writer !== 5'd0 || GPR_wd !== 32'd0 ||
            wb_valid !== 1'b0 || retire_cnt !== 32'd0) begin
            nfail++;
            $display("FAIL midreset_outputs got we=%b wr=%0d wd=%h v=%b cnt=%0d exp zeros",
                     GPR_we, GPR_writer, GPR_wd, wb_valid, retire_cnt);
        end
        nvec++;
        if (exu_ready !== 1'b1 || lsu_ready !== 1'b1 || chk_busy !== 1'b0) begin
            nfail++;
            $display("FAIL midreset_ready got exu=%b lsu=%b busy=%b exp 1 1 0",
                     exu_ready, lsu_ready, chk_busy);
        end
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++;
        if (exu_ready !== 1'b1) begin
            nfail++;
            $display("FAIL midreset_release got exu_ready=%b exp 1", exu_ready);
        end
        idle(5'd21);
        idle(5'd22);
        drain_check("midreset");
    endtask

    task automatic test_back_to_back();
        logic lf, xf;
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'h300 + 32'(i),
                  5'(i), lf, xf);
        idle(5'd8);
        nvec++;
        if (expq.size() != 0) begin
            nfail++;
            $display("FAIL b2b_rate got %0d pending exp 0", expq.size());
        end
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom,
                  5'($urandom_range(0, 7)), lf, xf);
        drain_check("random");
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        test_reset();
        test_bypass();
        test_simultaneous();
        test_full();
        test_rd0();
        test_wrap();
        test_midreset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
